log2_share_sched: RTL and testbench

//  Round-robin scheduler that shares one floor-log2 unit (BIT_IN-bit in, BIT_OUT-bit out,

---
 rtl/log2_share_sched.sv | 113 +++++++++++
 tb/tb_log2_share_sched.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/log2_share_sched.sv
// Round-robin scheduler sharing one fixed-latency floor-log2 unit among NREQ requesters.
// Results come back one-hot to the issuer; an enable/drain FSM lets it stop cleanly.
module log2_share_sched #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int BIT_IN  = 12,
    parameter int BIT_OUT = 4,
    parameter int LAT     = 2,
    parameter int CNTW    = 16
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   Enable,
    input  logic [NREQ-1:0]        ReqValid,
    input  logic [NREQ*BIT_IN-1:0] ReqData,
    output logic [NREQ-1:0]        ReqReady,
    output logic [BIT_IN-1:0]      LogIn,
    input  logic [BIT_OUT-1:0]     LogOut,
    output logic [NREQ-1:0]        RspValid,
    output logic [BIT_OUT-1:0]     RspData,
    output logic                   RspZero,
    output logic [IDW-1:0]         RspId,
    output logic                   Idle,
    output logic [CNTW-1:0]        IssueCnt
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} StateT;

    localparam logic [LAT-1:0] TAIL_BIT = LAT'(1) << (LAT - 1);

    StateT          state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] scanIdx;
    logic [IDW-1:0] grantIdx;
    logic           grantHit;
    logic [LAT-1:0] pipeVld;
    logic [LAT-1:0] pipeZero;
    logic [IDW-1:0] pipeId [LAT];
    logic           drainDone;

    // Scan from the pointer upward with wrap; the first valid requester wins.
    always_comb begin
        grantHit = 1'b0;
        grantIdx = '0;
        scanIdx  = '0;
        if (state == RUN && Enable) begin
            for (int k = 0; k < NREQ; k++) begin
                scanIdx = IDW'((int'(ptr) + k) % NREQ);
                if (!grantHit && ReqValid[scanIdx]) begin
                    grantHit = 1'b1;
                    grantIdx = scanIdx;
                end
            end
        end
    end

    assign ReqReady = grantHit ? (NREQ'(1) << grantIdx) : '0;
    assign LogIn    = grantHit ? ReqData[grantIdx*BIT_IN +: BIT_IN] : '0;
    assign Idle     = (state == IDLE);

    // The tail leaves the pipe on this edge, so ignoring it lets the last
    // response and the return to IDLE share one edge.
    assign drainDone = ((pipeVld & ~TAIL_BIT) == '0);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= IDLE;
            ptr      <= '0;
            IssueCnt <= '0;
            pipeVld  <= '0;
            pipeZero <= '0;
            for (int s = 0; s < LAT; s++) begin
                pipeId[s] <= '0;
            end
            RspValid <= '0;
            RspData  <= '0;
            RspZero  <= 1'b0;
            RspId    <= '0;
        end else begin
            case (state)
                IDLE:    if (Enable) state <= RUN;
                RUN:     if (!Enable) state <= DRAIN;
                DRAIN:   if (drainDone) state <= IDLE;
                default: state <= IDLE;
            endcase

            if (grantHit) begin
                ptr      <= (grantIdx == IDW'(NREQ - 1)) ? '0 : grantIdx + 1'b1;
                IssueCnt <= IssueCnt + 1'b1;
            end

            pipeVld[0]  <= grantHit;
            pipeZero[0] <= grantHit && (LogIn == '0);
            pipeId[0]   <= grantIdx;
            for (int s = 1; s < LAT; s++) begin
                pipeVld[s]  <= pipeVld[s-1];
                pipeZero[s] <= pipeZero[s-1];
                pipeId[s]   <= pipeId[s-1];
            end

            // The tail tag lines up with the unit's output in this cycle.
            if (pipeVld[LAT-1]) begin
                RspValid <= NREQ'(1) << pipeId[LAT-1];
                RspId    <= pipeId[LAT-1];
                RspZero  <= pipeZero[LAT-1];
                RspData  <= pipeZero[LAT-1] ? '0 : LogOut;
            end else begin
                RspValid <= '0;
            end
        end
    end

endmodule

// File: tb/tb_log2_share_sched.sv
// Scoreboard bench for log2_share_sched with a behavioural two-cycle log2 unit.
module tb_log2_share_sched;

    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int BIT_IN  = 12;
    localparam int BIT_OUT = 4;
    localparam int LAT     = 2;
    localparam int CNTW    = 16;

    logic                   Clk = 1'b0;
    logic                   Rst;
    logic                   Enable;
    logic [NREQ-1:0]        ReqValid;
    logic [NREQ*BIT_IN-1:0] ReqData;
    logic [NREQ-1:0]        ReqReady;
    logic [BIT_IN-1:0]      LogIn;
    logic [BIT_OUT-1:0]     LogOut = '0;
    logic [NREQ-1:0]        RspValid;
    logic [BIT_OUT-1:0]     RspData;
    logic                   RspZero;
    logic [IDW-1:0]         RspId;
    logic                   Idle;
    logic [CNTW-1:0]        IssueCnt;

    typedef struct {
        logic [IDW-1:0]     id;
        logic [BIT_OUT-1:0] data;
        logic               zero;
        int                 cyc;
    } SbEntry;

    SbEntry          sb[$];
    int              assertCnt = 0;
    int              failCnt = 0;
    int              cyc = 0;
    logic [CNTW-1:0] expCnt = '0;
    logic            cntPreload = 1'b0;
    logic [BIT_IN-1:0] luIn = '0;

    log2_share_sched #(
        .NREQ(NREQ), .IDW(IDW), .BIT_IN(BIT_IN), .BIT_OUT(BIT_OUT), .LAT(LAT), .CNTW(CNTW)
    ) dut (
        .Clk(Clk), .Rst(Rst), .Enable(Enable), .ReqValid(ReqValid), .ReqData(ReqData),
        .ReqReady(ReqReady), .LogIn(LogIn), .LogOut(LogOut), .RspValid(RspValid),
        .RspData(RspData), .RspZero(RspZero), .RspId(RspId), .Idle(Idle), .IssueCnt(IssueCnt)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    // Log2 unit: a zero operand yields all ones, so the scheduler must mask it.
    function automatic logic [BIT_OUT-1:0] unitLog2(input logic [BIT_IN-1:0] v);
        logic [BIT_OUT-1:0] r;
        r = '1;
        for (int i = 0; i < BIT_IN; i++) begin
            if (v[i]) r = BIT_OUT'(i);
        end
        return r;
    endfunction

    always @(posedge Clk) begin
        luIn   <= LogIn;
        LogOut <= unitLog2(luIn);
    end

    function automatic logic [BIT_OUT-1:0] expLog2(input logic [BIT_IN-1:0] v);
        logic [BIT_IN-1:0] t;
        logic [BIT_OUT-1:0] n;
        t = v;
        n = '0;
        while (t > 1) begin
            t = t >> 1;
            n = n + 1'b1;
        end
        return n;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCnt++;
        if (got !== exp) begin
            failCnt++;
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard: transfers push the expected answer, result strobes pop it.
    always @(negedge Clk) begin
        SbEntry e;
        logic [BIT_IN-1:0] v;
        if (Rst) begin
            sb.delete();
            expCnt = '0;
        end else begin
            if (cntPreload) expCnt = 16'hFFFF;
            checkOutput("issueCnt", 32'(IssueCnt), 32'(expCnt));
            if (RspValid != '0) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpRsp", 32'(RspValid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("rspValid", 32'(RspValid), 32'(NREQ'(1) << e.id));
                    checkOutput("rspId", 32'(RspId), 32'(e.id));
                    checkOutput("rspData", 32'(RspData), 32'(e.data));
                    checkOutput("rspZero", 32'(RspZero), 32'(e.zero));
                    checkOutput("rspLat", 32'(cyc - e.cyc), 32'(LAT + 1));
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (ReqValid[i] && ReqReady[i]) begin
                    v      = ReqData[i*BIT_IN +: BIT_IN];
                    e.id   = IDW'(i);
                    e.zero = (v == '0);
                    e.data = (v == '0) ? '0 : expLog2(v);
                    e.cyc  = cyc;
                    sb.push_back(e);
                    expCnt = expCnt + 1'b1;
                end
            end
        end
    end

    task automatic nextCycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] valid, input int idx, input logic [BIT_IN-1:0] data);
        ReqValid = valid;
        ReqData[idx*BIT_IN +: BIT_IN] = data;
        #1;
    endtask

    task automatic doReset();
        Rst      = 1'b1;
        Enable   = 1'b0;
        ReqValid = '0;
        nextCycle();
        nextCycle();
        Rst = 1'b0;
    endtask

    task automatic waitDrain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            nextCycle();
            n++;
        end
        if (sb.size() != 0) checkOutput("drainTimeout", 32'(sb.size()), 32'd0);
        nextCycle();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [BIT_IN-1:0] ops [4];
        ops[0] = 12'd0;
        ops[1] = 12'd1;
        ops[2] = 12'd4095;
        ops[3] = 12'd2048;
        Rst      = 1'b1;
        Enable   = 1'b0;
        ReqValid = '0;
        ReqData  = '0;
        repeat (3) nextCycle();
        checkOutput("rstIdle", 32'(Idle), 32'd1);
        checkOutput("rstRspValid", 32'(RspValid), 32'd0);
        checkOutput("rstRspData", 32'(RspData), 32'd0);
        checkOutput("rstRspZero", 32'(RspZero), 32'd0);
        checkOutput("rstRspId", 32'(RspId), 32'd0);
        checkOutput("rstIssueCnt", 32'(IssueCnt), 32'd0);
        Rst = 1'b0;

        $display("[TB] single op from requester 0");
        Enable = 1'b1;
        nextCycle();
        applyStimulus(4'b0001, 0, 12'd1024);
        checkOutput("t1Ready", 32'(ReqReady), 32'b0001);
        checkOutput("t1LogIn", 32'(LogIn), 32'd1024);
        nextCycle();
        ReqValid = '0;
        checkOutput("t1EarlyRsp", 32'(RspValid), 32'd0);
        nextCycle();
        checkOutput("t1EarlyRsp", 32'(RspValid), 32'd0);
        nextCycle();
        checkOutput("t1RspValid", 32'(RspValid), 32'b0001);
        checkOutput("t1RspData", 32'(RspData), 32'd10);
        waitDrain(10);

        $display("[TB] round robin with all requesters valid");
        doReset();
        Enable = 1'b1;
        nextCycle();
        ReqData = {12'd77, 12'd2048, 12'd300, 12'd5};
        ReqValid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            checkOutput("t2Grant", 32'(ReqReady), 32'(1 << (k % NREQ)));
            nextCycle();
        end
        ReqValid = '0;
        waitDrain(10);
        checkOutput("t2IssueCnt", 32'(IssueCnt), 32'd8);

        $display("[TB] zero and boundary operands from requester 2");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(4'b0100, 2, ops[k]);
            checkOutput("t3Grant", 32'(ReqReady), 32'b0100);
            nextCycle();
        end
        ReqValid = '0;
        waitDrain(10);

        $display("[TB] enable drop drains in-flight ops");
        applyStimulus(4'b0001, 0, 12'd7);
        checkOutput("t4Grant0", 32'(ReqReady), 32'b0001);
        nextCycle();
        applyStimulus(4'b0010, 1, 12'd300);
        checkOutput("t4Grant1", 32'(ReqReady), 32'b0010);
        nextCycle();
        Enable   = 1'b0;
        ReqValid = 4'b1111;
        #1;
        checkOutput("t4EnLowNoGrant", 32'(ReqReady), 32'd0);
        nextCycle();
        Enable = 1'b1;
        #1;
        checkOutput("t4DrainNoGrant", 32'(ReqReady), 32'd0);
        checkOutput("t4DrainIdle", 32'(Idle), 32'd0);
        checkOutput("t4Rsp0", 32'(RspValid), 32'b0001);
        nextCycle();
        checkOutput("t4IdleAfterDrain", 32'(Idle), 32'd1);
        checkOutput("t4Rsp1", 32'(RspValid), 32'b0010);
        checkOutput("t4IdleNoGrant", 32'(ReqReady), 32'd0);
        nextCycle();
        checkOutput("t4RunAgain", 32'(Idle), 32'd0);
        checkOutput("t4Resume", 32'(ReqReady), 32'b0100);
        nextCycle();
        ReqValid = '0;
        waitDrain(10);

        $display("[TB] reset with ops in flight");
        ReqValid = 4'b1111;
        nextCycle();
        nextCycle();
        Rst = 1'b1;
        nextCycle();
        checkOutput("t5RspValid", 32'(RspValid), 32'd0);
        checkOutput("t5Idle", 32'(Idle), 32'd1);
        checkOutput("t5IssueCnt", 32'(IssueCnt), 32'd0);
        Rst      = 1'b0;
        ReqValid = '0;
        Enable   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            nextCycle();
            checkOutput("t5NoLateRsp", 32'(RspValid), 32'd0);
        end
        ReqValid = 4'b1111;
        #1;
        checkOutput("t5PtrZero", 32'(ReqReady), 32'b0001);
        ReqValid = '0;
        nextCycle();

        $display("[TB] issue counter wrap");
        force dut.IssueCnt = 16'hFFFF;
        cntPreload = 1'b1;
        ReqData[0 +: BIT_IN] = 12'd4;
        ReqValid = 4'b0001;
        #1;
        release dut.IssueCnt;
        nextCycle();
        ReqValid   = '0;
        cntPreload = 1'b0;
        checkOutput("t6Wrap", 32'(IssueCnt), 32'd0);
        waitDrain(10);

        repeat (3) nextCycle();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
        $finish;
    end

endmodule
